// File: rtl/stopwatch_bcd_ctrl.sv
// stopwatch_bcd_ctrl
//   Stopwatch front end for the per-digit segment decoders. It debounces the
//   start/stop and clear buttons, divides clk_50MHz down to a count tick, runs
//   the IDLE/RUN/PAUSE sequencer and holds a two-digit BCD count (00-99).
//
// Ports
//   clk_50MHz       in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   btn_start_stop  in   raw start/stop push button, active-high
//   btn_clear       in   raw clear push button, active-high
//   ones            out  BCD units digit (registered)
//   tens            out  BCD tens digit (registered)
//   hundreds        out  guard digit, always 0
//   running         out  1 while in RUN (registered)
//   wrap_pulse      out  one-cycle pulse on the 99 -> 00 wrap
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | stopped at 00, prescaler held at 0, waiting for start
// S_RUN   | prescaler advancing, count increments on each tick
// S_PAUSE | count and prescaler frozen, start resumes the interval

module stopwatch_bcd_ctrl #(
    parameter int TICK_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       running,
    output logic       wrap_pulse
);

    localparam int PS_W = $clog2(TICK_DIV);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Button path, index 0 = start/stop, index 1 = clear
    logic [1:0]      raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      deb_q;
    logic [1:0]      deb_prev_q;
    logic [1:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [2];

    assign raw = {btn_clear, btn_start_stop};

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            // Rising edge of the debounced level only; releases never press.
            press_q    <= deb_q & ~deb_prev_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == deb_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_LAST) begin
                    deb_q[b]    <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    logic start_press;
    logic clear_press;
    assign start_press = press_q[0];
    assign clear_press = press_q[1];

    // Sequencer, prescaler and BCD count
    state_t          state_q;
    logic [PS_W-1:0] presc_q;
    logic [3:0]      ones_q;
    logic [3:0]      tens_q;
    logic            running_q;
    logic            wrap_q;

    logic            tick;
    logic [3:0]      ones_d;
    logic [3:0]      tens_d;
    logic            wrap_d;

    assign tick = (state_q == S_RUN) && (presc_q == PS_LAST);

    always_comb begin
        ones_d = ones_q + 4'd1;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (ones_q >= 4'd9) begin
            ones_d = 4'd0;
            if (tens_q >= 4'd9) begin
                tens_d = 4'd0;
                wrap_d = 1'b1;
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clear_press) begin
                // Clear overrides everything, including a coincident tick or start.
                state_q   <= S_IDLE;
                running_q <= 1'b0;
                presc_q   <= '0;
                ones_q    <= 4'd0;
                tens_q    <= 4'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        presc_q <= '0;
                        if (start_press) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        presc_q <= tick ? '0 : presc_q + PS_W'(1);
                        if (tick) begin
                            ones_q <= ones_d;
                            tens_q <= tens_d;
                            wrap_q <= wrap_d;
                        end
                        if (start_press) begin
                            state_q   <= S_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        // Prescaler is left alone so resume finishes the interval.
                        if (start_press) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                        presc_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign ones       = ones_q;
    assign tens       = tens_q;
    assign hundreds   = 4'd0;
    assign running    = running_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
module tb_stopwatch_bcd_ctrl;

    logic       clk_50MHz;
    logic       reset;
    logic       btn_start_stop;
    logic       btn_clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       running;
    logic       wrap_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_bcd_ctrl #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk_50MHz      (clk_50MHz),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .ones           (ones),
        .tens           (tens),
        .hundreds       (hundreds),
        .running        (running),
        .wrap_pulse     (wrap_pulse)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic       start;
        logic       clear;
        logic [3:0] e_ones;
        logic [3:0] e_tens;
        logic       e_run;
        logic       e_wrap;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Called at a falling edge: drive buttons, take one rising edge, return at the next falling edge.
    task automatic cyc(input logic s, input logic c);
        btn_start_stop = s;
        btn_clear      = c;
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
    endtask

    task automatic chk_cnt(input string nm, input int o, input int t, input logic r);
        chk({nm, "_ones"}, {4'd0, ones}, 8'(o));
        chk({nm, "_tens"}, {4'd0, tens}, 8'(t));
        chk({nm, "_run"}, {7'd0, running}, {7'd0, r});
    endtask

    // Clear press: takes effect on edge 7, then settle so both debounced levels are back at 0.
    task automatic clear_seq(input string nm);
        for (int e = 1; e <= 12; e++) cyc(1'b0, e <= 4);
        chk_cnt(nm, 0, 0, 1'b0);
    endtask

    initial begin
        int n;
        int wraps;

        // Edges 1-10 start held; press on 6, RUN on 7, ticks every 4 from edge 11.
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};

        reset          = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        chk_cnt("reset", 0, 0, 1'b0);
        chk("reset_hund", {4'd0, hundreds}, 8'd0);
        chk("reset_wrap", {7'd0, wrap_pulse}, 8'd0);
        reset = 1'b1;

        // 1: start held, table-driven
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].start, tbl[i].clear);
            chk_cnt($sformatf("t1_row%0d", i + 1), int'(tbl[i].e_ones), int'(tbl[i].e_tens), tbl[i].e_run);
            chk("t1_wrap", {7'd0, wrap_pulse}, {7'd0, tbl[i].e_wrap});
            chk("t1_hund", {4'd0, hundreds}, 8'd0);
        end

        // 2: keep running through four wraps; count n appears on edge 11+4(n-1)
        wraps = 0;
        for (int i = 21; i <= 1620; i++) begin
            cyc(1'b0, 1'b0);
            n = (i - 11) / 4 + 1;
            chk("t2_ones", {4'd0, ones}, 8'(n % 10));
            chk("t2_tens", {4'd0, tens}, 8'((n / 10) % 10));
            chk("t2_wrap", {7'd0, wrap_pulse}, {7'd0, ((n % 100) == 0) && (((i - 11) % 4) == 0)});
            chk("t2_hund", {4'd0, hundreds}, 8'd0);
            if (wrap_pulse === 1'b1) wraps++;
        end
        chk("t2_wrap_count", 8'(wraps), 8'd4);

        // 3: pause at 05, resume finishes the partial interval
        clear_seq("t3_clear");
        for (int e = 1; e <= 62; e++) begin
            cyc((e <= 4) || (e >= 24 && e <= 27) || (e >= 51 && e <= 54), 1'b0);
            if (e == 6)  chk_cnt("t3_pre_run", 0, 0, 1'b0);
            if (e == 7)  chk_cnt("t3_run", 0, 0, 1'b1);
            if (e == 27) chk_cnt("t3_at05", 5, 0, 1'b1);
            if (e == 29) chk_cnt("t3_pre_pause", 5, 0, 1'b1);
            if (e >= 30 && e <= 56) chk_cnt("t3_frozen", 5, 0, 1'b0);
            if (e == 57) chk_cnt("t3_resume", 5, 0, 1'b1);
            if (e == 58) chk_cnt("t3_first_tick", 6, 0, 1'b1);
            if (e == 62) chk_cnt("t3_next_tick", 7, 0, 1'b1);
        end

        // 4: bouncing start gives no press; a clean 3-cycle hold gives exactly one
        clear_seq("t4_clear");
        for (int e = 1; e <= 60; e++) begin
            cyc((e <= 20 && ((e - 1) % 4) < 2) || (e >= 31 && e <= 33), 1'b0);
            if (e <= 36) chk_cnt("t4_bounce", 0, 0, 1'b0);
            if (e >= 37) chk("t4_run", {7'd0, running}, 8'd1);
            if (e == 41) chk_cnt("t4_tick", 1, 0, 1'b1);
            if (e == 60) chk_cnt("t4_end", 5, 0, 1'b1);
        end

        // 5a: pause at 37, then start and clear presses coincide
        clear_seq("t5_clear");
        for (int e = 1; e <= 180; e++) begin
            cyc((e <= 4) || (e >= 151 && e <= 154) || (e >= 161 && e <= 164),
                (e >= 161 && e <= 164));
            if (e == 155) chk_cnt("t5_at37", 7, 3, 1'b1);
            if (e == 156) chk_cnt("t5_pre_pause", 7, 3, 1'b1);
            if (e >= 157 && e <= 166) chk_cnt("t5_paused", 7, 3, 1'b0);
            if (e >= 167) chk_cnt("t5_cleared_idle", 0, 0, 1'b0);
        end

        // 5b: clear lands on a tick edge in RUN
        for (int e = 1; e <= 30; e++) begin
            cyc(e <= 4, (e >= 13 && e <= 16));
            if (e == 18) chk_cnt("t5b_pre", 2, 0, 1'b1);
            if (e == 19) begin
                chk_cnt("t5b_tick_clear", 0, 0, 1'b0);
                chk("t5b_wrap", {7'd0, wrap_pulse}, 8'd0);
            end
            if (e == 30) chk_cnt("t5b_idle", 0, 0, 1'b0);
        end
        clear_seq("t5c_clear_in_idle");

        // 6: asynchronous reset mid-run at 42
        for (int e = 1; e <= 175; e++) begin
            cyc(e <= 4, 1'b0);
            if (e == 175) chk_cnt("t6_at42", 2, 4, 1'b1);
        end
        #2 reset = 1'b0;
        #1;
        chk_cnt("t6_async", 0, 0, 1'b0);
        chk("t6_wrap", {7'd0, wrap_pulse}, 8'd0);
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        reset = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            cyc(1'b0, 1'b0);
            chk_cnt("t6_hold", 0, 0, 1'b0);
        end
        for (int e = 1; e <= 12; e++) begin
            cyc(e <= 4, 1'b0);
            if (e == 6)  chk_cnt("t6_pre_start", 0, 0, 1'b0);
            if (e == 7)  chk_cnt("t6_start", 0, 0, 1'b1);
            if (e == 11) chk_cnt("t6_tick", 1, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
